// File: rtl/link_msg_tx_pkg.sv
`default_nettype none
// Shared widths, parameter defaults and FSM encoding for the link message transmitter.
package link_msg_tx_pkg;

  localparam int WORD_W  = 16;
  localparam int LEN_W   = 8;
  localparam int TIMER_W = 9;
  localparam int DEF_DIV = 2;
  localparam int DEF_GAP = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STALL = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/link_bit_timer.sv
`default_nettype none
// Bit-period timer: DIV low cycles then DIV high cycles of serial clock,
// with a strobe on the last cycle of each period.
module link_bit_timer
  import link_msg_tx_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic bit_end
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(2 * DIV - 1);
  localparam logic [TIMER_W-1:0] HALF = TIMER_W'(DIV);

  logic [TIMER_W-1:0] cnt;

  // Counter parks at zero whenever the timer is not running, so every run
  // starts at the beginning of a low phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  assign sck     = run && (cnt >= HALF);
  assign bit_end = run && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/link_msg_tx.sv
`default_nettype none
// Serialises MSG_LEN FIFO words MSB first with mid-word prefetch, underrun
// stalling and an idle gap after each message.
module link_msg_tx
  import link_msg_tx_pkg::*;
#(
  parameter int DIV = DEF_DIV,
  parameter int GAP = DEF_GAP
) (
  input  logic              CLK_IN,
  input  logic              RST,
  input  logic              MSG_START,
  input  logic [LEN_W-1:0]  MSG_LEN,
  input  logic [WORD_W-1:0] FIFO_Q,
  input  logic              FIFO_EMPTY,
  output logic              RD_REQ,
  output logic              TX_SCK,
  output logic              TX_DATA,
  output logic              TX_LOAD,
  output logic              TX_STOP,
  output logic              BUSY,
  output logic              UNDERRUN
);

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t             state, state_d;
  logic [LEN_W-1:0]   word_cnt, word_cnt_d;
  logic [WORD_W-1:0]  shreg, shreg_d;
  logic [WORD_W-1:0]  nxt_word, nxt_word_d;
  logic               nxt_valid, nxt_valid_d;
  logic [3:0]         bit_pos, bit_pos_d;
  logic [3:0]         gap_cnt, gap_cnt_d;
  logic               rd, rd_pend;
  logic               underrun_d, underrun_q;
  logic               in_shift, last_word;
  logic               timer_sck, bit_end;

  assign in_shift  = (state == ST_SHIFT);
  // word_cnt counts words not yet latched, so the word on the wire is final
  // once nothing remains upstream and nothing is held in the prefetch slot.
  assign last_word = (word_cnt == '0) && !nxt_valid;

  link_bit_timer #(.DIV(DIV)) u_timer (
    .clk     (CLK_IN),
    .rst_n   (RST),
    .run     (in_shift || (state == ST_GAP)),
    .sck     (timer_sck),
    .bit_end (bit_end)
  );

  always_ff @(posedge CLK_IN) begin
    if (!RST) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      shreg      <= '0;
      nxt_word   <= '0;
      nxt_valid  <= 1'b0;
      bit_pos    <= '0;
      gap_cnt    <= '0;
      rd_pend    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_d;
      word_cnt   <= word_cnt_d;
      shreg      <= shreg_d;
      nxt_word   <= nxt_word_d;
      nxt_valid  <= nxt_valid_d;
      bit_pos    <= bit_pos_d;
      gap_cnt    <= gap_cnt_d;
      rd_pend    <= rd;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state;
    word_cnt_d  = word_cnt;
    shreg_d     = shreg;
    nxt_word_d  = nxt_word;
    nxt_valid_d = nxt_valid;
    bit_pos_d   = bit_pos;
    gap_cnt_d   = gap_cnt;
    underrun_d  = 1'b0;
    rd          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (MSG_START && (MSG_LEN != '0)) begin
          state_d    = ST_FETCH;
          word_cnt_d = MSG_LEN;
        end
      end
      ST_FETCH: begin
        if (rd_pend) begin
          shreg_d    = FIFO_Q;
          word_cnt_d = word_cnt - LEN_W'(1);
          bit_pos_d  = 4'd15;
          state_d    = ST_SHIFT;
        end else if (!FIFO_EMPTY) begin
          rd = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rd_pend) begin
          nxt_word_d  = FIFO_Q;
          nxt_valid_d = 1'b1;
          word_cnt_d  = word_cnt - LEN_W'(1);
        end else if ((word_cnt != '0) && !nxt_valid && (bit_pos <= 4'd8) && !FIFO_EMPTY) begin
          rd = 1'b1;
        end
        if (bit_end) begin
          if (bit_pos != 4'd0) begin
            shreg_d   = {shreg[WORD_W-2:0], 1'b0};
            bit_pos_d = bit_pos - 4'd1;
          end else if (last_word) begin
            state_d   = ST_GAP;
            gap_cnt_d = 4'd0;
          end else if (nxt_valid) begin
            shreg_d     = nxt_word;
            nxt_valid_d = 1'b0;
            bit_pos_d   = 4'd15;
          end else if (rd_pend) begin
            // Prefetched word arrives exactly at the word boundary.
            shreg_d     = FIFO_Q;
            nxt_valid_d = 1'b0;
            bit_pos_d   = 4'd15;
          end else if (rd) begin
            state_d = ST_FETCH;
          end else begin
            state_d    = ST_STALL;
            underrun_d = 1'b1;
          end
        end
      end
      ST_STALL: begin
        if (!FIFO_EMPTY) begin
          rd      = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_GAP: begin
        if (bit_end) begin
          if (gap_cnt == GAP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign RD_REQ   = rd;
  assign TX_SCK   = in_shift && timer_sck;
  assign TX_DATA  = in_shift && shreg[WORD_W-1];
  assign TX_LOAD  = in_shift && (bit_pos == 4'd0);
  assign TX_STOP  = TX_LOAD && last_word;
  assign BUSY     = (state != ST_IDLE);
  assign UNDERRUN = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_link_msg_tx.sv
`default_nettype none
// Scoreboard bench for link_msg_tx: DIV=2 instance for most scenarios,
// DIV=1 instance for the maximum-length message.
module tb_link_msg_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  msg_len = 8'd0;
  logic [15:0] fifo_q = 16'd0;
  bit          sel = 1'b0;
  bit          flush = 1'b0;

  logic rd0, sck0, data0, load0, stop0, busy0, under0;
  logic rd1, sck1, data1, load1, stop1, busy1, under1;
  logic start0, start1, empty0, empty1, f_empty;
  logic m_rd, m_sck, m_data, m_load, m_stop, m_busy, m_under;

  logic [15:0] mem [512];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic [2:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int n_rd = 0, n_bits = 0, n_load_bits = 0, n_stop_bits = 0;
  int n_sck_hi = 0, n_under = 0;
  logic prev_sck = 1'b0;

  always #5 clk = ~clk;

  assign f_empty = (rd_ptr == wr_ptr);
  assign start0  = start && !sel;
  assign start1  = start && sel;
  assign empty0  = sel ? 1'b1 : f_empty;
  assign empty1  = sel ? f_empty : 1'b1;
  assign m_rd    = sel ? rd1 : rd0;
  assign m_sck   = sel ? sck1 : sck0;
  assign m_data  = sel ? data1 : data0;
  assign m_load  = sel ? load1 : load0;
  assign m_stop  = sel ? stop1 : stop0;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_under = sel ? under1 : under0;

  link_msg_tx #(.DIV(2), .GAP(4)) dut0 (
    .CLK_IN(clk), .RST(rst_n), .MSG_START(start0), .MSG_LEN(msg_len),
    .FIFO_Q(fifo_q), .FIFO_EMPTY(empty0), .RD_REQ(rd0), .TX_SCK(sck0),
    .TX_DATA(data0), .TX_LOAD(load0), .TX_STOP(stop0), .BUSY(busy0),
    .UNDERRUN(under0)
  );

  link_msg_tx #(.DIV(1), .GAP(4)) dut1 (
    .CLK_IN(clk), .RST(rst_n), .MSG_START(start1), .MSG_LEN(msg_len),
    .FIFO_Q(fifo_q), .FIFO_EMPTY(empty1), .RD_REQ(rd1), .TX_SCK(sck1),
    .TX_DATA(data1), .TX_LOAD(load1), .TX_STOP(stop1), .BUSY(busy1),
    .UNDERRUN(under1)
  );

  // Upstream FIFO: word appears on fifo_q the cycle after a read strobe.
  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (m_rd && !f_empty) begin
      fifo_q <= mem[rd_ptr % 512];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor: each rising TX_SCK samples one bit and pops the scoreboard.
  always @(negedge clk) begin
    logic [2:0] e;
    if (m_rd) begin
      n_rd++;
      checks++;
      if (f_empty) begin
        errors++;
        $display("FAIL rd_while_empty: RD_REQ=1 with FIFO_EMPTY=1, required RD_REQ=0 (t=%0t)", $time);
      end
    end
    if (m_sck && !prev_sck) begin
      n_bits++;
      if (m_load) n_load_bits++;
      if (m_stop) n_stop_bits++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bit_unexpected: got data/load/stop=%b%b%b, required no bit (t=%0t)",
                 m_data, m_load, m_stop, $time);
      end else begin
        e = exp_q.pop_front();
        if ({m_data, m_load, m_stop} !== e) begin
          errors++;
          $display("FAIL bit_value: got data/load/stop=%b%b%b, required %b (bit %0d, t=%0t)",
                   m_data, m_load, m_stop, e, n_bits, $time);
        end
      end
    end
    if (m_sck) n_sck_hi++;
    if (m_under) n_under++;
    prev_sck = m_sck;
  end

  task automatic push_word(input logic [15:0] w);
    mem[wr_ptr % 512] = w;
    wr_ptr++;
  endtask

  task automatic push_exp(input logic [15:0] w, input bit last);
    for (int b = 15; b >= 0; b--) exp_q.push_back({w[b], b == 0, (b == 0) && last});
  endtask

  task automatic start_msg(input logic [7:0] len);
    @(negedge clk);
    start = 1'b1;
    msg_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Returns busy cycles seen (-1 on timeout) and cycles since TX_STOP last high.
  task automatic run_until_idle(input int maxc, output int cyc, output int since_stop);
    cyc = -1;
    since_stop = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk); #1;
      if (!m_busy) begin
        cyc = i;
        return;
      end
      if (m_stop) since_stop = 0;
      else since_stop++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rd0, sck0, data0, load0, stop0, busy0, under0} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs_div2: got %b, required 0000000",
               {rd0, sck0, data0, load0, stop0, busy0, under0});
    end
    checks++;
    if ({rd1, sck1, data1, load1, stop1, busy1, under1} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs_div1: got %b, required 0000000",
               {rd1, sck1, data1, load1, stop1, busy1, under1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    int b_bits, b_sck, b_rd, b_stop, cyc, gap;
    b_bits = n_bits; b_sck = n_sck_hi; b_rd = n_rd; b_stop = n_stop_bits;
    push_word(16'hA5C3);
    push_exp(16'hA5C3, 1'b1);
    start_msg(8'd1);
    run_until_idle(500, cyc, gap);
    checks++;
    if (cyc !== 82) begin
      errors++;
      $display("FAIL single_busy_cycles: got %0d, required 82", cyc);
    end
    checks++;
    if (gap !== 16) begin
      errors++;
      $display("FAIL single_gap: got %0d, required 16", gap);
    end
    checks++;
    if (n_sck_hi - b_sck !== 32) begin
      errors++;
      $display("FAIL single_sck_high: got %0d, required 32", n_sck_hi - b_sck);
    end
    checks++;
    if ({n_bits - b_bits, n_rd - b_rd, n_stop_bits - b_stop} !== {32'd16, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL single_counts: bits/rd/stop got %0d/%0d/%0d, required 16/1/1",
               n_bits - b_bits, n_rd - b_rd, n_stop_bits - b_stop);
    end
  endtask

  task automatic test_back_to_back();
    int b_bits, b_rd, b_load, b_stop, b_und, cyc, gap;
    b_bits = n_bits; b_rd = n_rd; b_load = n_load_bits; b_stop = n_stop_bits; b_und = n_under;
    push_word(16'h0001); push_word(16'h8000); push_word(16'hFFFF);
    push_exp(16'h0001, 1'b0); push_exp(16'h8000, 1'b0); push_exp(16'hFFFF, 1'b1);
    start_msg(8'd3);
    run_until_idle(1000, cyc, gap);
    checks++;
    if (cyc !== 210) begin
      errors++;
      $display("FAIL b2b_busy_cycles: got %0d, required 210 (contiguous words)", cyc);
    end
    checks++;
    if (n_rd - b_rd !== 3) begin
      errors++;
      $display("FAIL b2b_rd_count: got %0d, required 3", n_rd - b_rd);
    end
    checks++;
    if ({n_bits - b_bits, n_load_bits - b_load, n_stop_bits - b_stop, n_under - b_und}
        !== {32'd48, 32'd3, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL b2b_counts: bits/load/stop/underrun got %0d/%0d/%0d/%0d, required 48/3/1/0",
               n_bits - b_bits, n_load_bits - b_load, n_stop_bits - b_stop, n_under - b_und);
    end
  endtask

  task automatic test_underrun();
    int b_bits, b_rd, b_sck, b_und, s0, cyc, gap, waited;
    b_bits = n_bits; b_rd = n_rd; b_sck = n_sck_hi; b_und = n_under;
    push_word(16'h1234);
    push_exp(16'h1234, 1'b0); push_exp(16'hBEEF, 1'b1);
    start_msg(8'd2);
    waited = 0;
    while (!m_under && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if ({m_under, m_sck, m_data, m_load, m_stop} !== 5'b10000) begin
      errors++;
      $display("FAIL stall_entry: underrun/sck/data/load/stop got %b, required 10000",
               {m_under, m_sck, m_data, m_load, m_stop});
    end
    s0 = n_sck_hi;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (n_sck_hi - s0 !== 0) begin
      errors++;
      $display("FAIL stall_sck_idle: got %0d high cycles, required 0", n_sck_hi - s0);
    end
    @(negedge clk);
    push_word(16'hBEEF);
    run_until_idle(1000, cyc, gap);
    checks++;
    if (gap !== 16) begin
      errors++;
      $display("FAIL underrun_gap: got %0d, required 16", gap);
    end
    checks++;
    if ({n_under - b_und, n_rd - b_rd, n_bits - b_bits, n_sck_hi - b_sck}
        !== {32'd1, 32'd2, 32'd32, 32'd64}) begin
      errors++;
      $display("FAIL underrun_counts: underrun/rd/bits/sck got %0d/%0d/%0d/%0d, required 1/2/32/64",
               n_under - b_und, n_rd - b_rd, n_bits - b_bits, n_sck_hi - b_sck);
    end
  endtask

  task automatic test_ignored_starts();
    int b_rd, b_sck, b_bits, cyc, gap;
    bit busy_seen;
    b_rd = n_rd; b_sck = n_sck_hi;
    push_word(16'h5A5A);
    start_msg(8'd0);
    busy_seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (m_busy) busy_seen = 1'b1;
    end
    checks++;
    if ({busy_seen, n_rd - b_rd, n_sck_hi - b_sck} !== {1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL len0_ignored: busy/rd/sck got %0d/%0d/%0d, required 0/0/0",
               busy_seen, n_rd - b_rd, n_sck_hi - b_sck);
    end
    b_rd = n_rd; b_bits = n_bits;
    push_word(16'h0F0F); push_word(16'h7777);
    push_exp(16'h5A5A, 1'b0); push_exp(16'h0F0F, 1'b1);
    start_msg(8'd2);
    repeat (10) @(negedge clk);
    start = 1'b1;
    msg_len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    run_until_idle(1000, cyc, gap);
    checks++;
    if (gap !== 16) begin
      errors++;
      $display("FAIL busy_start_gap: got %0d, required 16", gap);
    end
    repeat (10) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({m_busy, n_rd - b_rd, n_bits - b_bits} !== {1'b0, 32'd2, 32'd32}) begin
      errors++;
      $display("FAIL busy_start_ignored: busy/rd/bits got %0d/%0d/%0d, required 0/2/32",
               m_busy, n_rd - b_rd, n_bits - b_bits);
    end
    do_flush();
  endtask

  task automatic test_reset_mid();
    int b_bits, b_rd, cyc, gap, waited;
    b_bits = n_bits;
    push_word(16'h1357); push_word(16'h9BDF); push_word(16'h2468); push_word(16'hACE0);
    push_exp(16'h1357, 1'b0);
    for (int b = 15; b >= 5; b--) exp_q.push_back({1'b0, 1'b0, 1'b0} | {3'(16'h9BDF >> b) & 3'b001, 2'b00});
    start_msg(8'd4);
    waited = 0;
    while ((n_bits - b_bits) < 27 && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (n_bits - b_bits !== 27) begin
      errors++;
      $display("FAIL reset_mid_reach: got %0d bits, required 27", n_bits - b_bits);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rd0, sck0, data0, load0, stop0, busy0, under0} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b, required 0000000",
               {rd0, sck0, data0, load0, stop0, busy0, under0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    b_rd = n_rd;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({n_rd - b_rd, exp_q.size()} !== {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid_abort: rd/pending_bits got %0d/%0d, required 0/0",
               n_rd - b_rd, exp_q.size());
    end
    do_flush();
    b_bits = n_bits;
    push_word(16'hC0DE);
    push_exp(16'hC0DE, 1'b1);
    start_msg(8'd1);
    run_until_idle(500, cyc, gap);
    checks++;
    if ({cyc, n_bits - b_bits} !== {32'd82, 32'd16}) begin
      errors++;
      $display("FAIL reset_mid_restart: busy/bits got %0d/%0d, required 82/16", cyc, n_bits - b_bits);
    end
  endtask

  task automatic test_long_div1();
    int b_rd, b_bits, b_load, b_stop, b_und, cyc, gap;
    logic [15:0] w;
    sel = 1'b1;
    b_rd = n_rd; b_bits = n_bits; b_load = n_load_bits; b_stop = n_stop_bits; b_und = n_under;
    for (int i = 0; i < 257; i++) begin
      w = 16'(i * 16'h0101) ^ 16'h3C5A;
      push_word(w);
      if (i < 255) push_exp(w, i == 254);
    end
    start_msg(8'd255);
    run_until_idle(9000, cyc, gap);
    checks++;
    if (cyc !== 8170) begin
      errors++;
      $display("FAIL long_busy_cycles: got %0d, required 8170", cyc);
    end
    checks++;
    if ({n_rd - b_rd, n_bits - b_bits, n_load_bits - b_load, n_stop_bits - b_stop, n_under - b_und}
        !== {32'd255, 32'd4080, 32'd255, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL long_counts: rd/bits/load/stop/underrun got %0d/%0d/%0d/%0d/%0d, required 255/4080/255/1/0",
               n_rd - b_rd, n_bits - b_bits, n_load_bits - b_load, n_stop_bits - b_stop, n_under - b_und);
    end
    do_flush();
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_ignored_starts();
    test_reset_mid();
    test_long_div1();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d bits outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
